// File: rtl/ring_phase_decoder_if.sv
// Bundle of ring-code inputs and decoded status outputs for ring_phase_decoder.
// The dir member exists only when RING_DEC_BIDIR_EN is defined.
interface ring_phase_decoder_if #(
    parameter int WIDTH = 4,
    parameter int REV_W = 8
);
    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] ring_in;
    logic             adv;
    logic [PW-1:0]    phase;
    logic             phase_valid;
    logic             locked;
    logic             err_pulse;
    logic [REV_W-1:0] rev_cnt;
    logic             wrap_pulse;
`ifdef RING_DEC_BIDIR_EN
    logic             dir;

    modport master (
        output ring_in, adv,
        input  phase, phase_valid, locked, err_pulse, rev_cnt, wrap_pulse, dir
    );
    modport slave (
        input  ring_in, adv,
        output phase, phase_valid, locked, err_pulse, rev_cnt, wrap_pulse, dir
    );
`else
    modport master (
        output ring_in, adv,
        input  phase, phase_valid, locked, err_pulse, rev_cnt, wrap_pulse
    );
    modport slave (
        input  ring_in, adv,
        output phase, phase_valid, locked, err_pulse, rev_cnt, wrap_pulse
    );
`endif
endinterface

// File: rtl/ring_phase_decoder.sv
// One-hot ring code decoder with step checking, lock FSM and revolution counter.
// Define RING_DEC_BIDIR_EN to accept and lock onto reverse-running rings (adds dir).
module ring_phase_decoder #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int REV_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ring_phase_decoder_if.slave  bus
);
    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {ACQ, LOCK, ERR} state_t;

    state_t           state_reg, state_next;
    logic [PW-1:0]    phase_reg, phase_next;
    logic             valid_reg, valid_next;
    logic             err_reg, err_next;
    logic [REV_W-1:0] rev_reg, rev_next;
    logic             wrap_reg, wrap_next;
    logic [GW-1:0]    good_cnt_reg, good_cnt_next;
    logic             have_prev_reg, have_prev_next;
`ifdef RING_DEC_BIDIR_EN
    logic             dir_reg, dir_next;
    logic             acq_dir_reg, acq_dir_next;
    logic             run_dir;
    logic             step_rev;
    logic [PW-1:0]    prev_minus;
`endif

    logic [PW-1:0] idx_term [WIDTH];
    logic [PW-1:0] dec_phase;
    logic          legal;
    logic [PW-1:0] prev_plus;
    logic          step_fwd;
    logic          lock_step_ok;
    logic          lock_wrap;
    logic [GW-1:0] acq_cnt;
    logic          acq_lock;

    // Each set bit contributes its phase index; only meaningful when legal.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
        assign idx_term[gi] = bus.ring_in[gi] ? PW'(WIDTH - 1 - gi) : '0;
    end

    always_comb begin
        dec_phase = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec_phase = dec_phase | idx_term[i];
        end
    end

    assign legal     = (bus.ring_in != '0) &&
                       ((bus.ring_in & (bus.ring_in - WIDTH'(1))) == '0);
    assign prev_plus = (phase_reg == PW'(WIDTH - 1)) ? '0 : phase_reg + PW'(1);
    assign step_fwd  = have_prev_reg && (dec_phase == prev_plus);

`ifdef RING_DEC_BIDIR_EN
    assign prev_minus   = (phase_reg == '0) ? PW'(WIDTH - 1) : phase_reg - PW'(1);
    assign step_rev     = have_prev_reg && (dec_phase == prev_minus);
    assign lock_step_ok = dir_reg ? step_rev : step_fwd;
    assign lock_wrap    = dir_reg ? (phase_reg == '0 && dec_phase == PW'(WIDTH - 1))
                                  : (phase_reg == PW'(WIDTH - 1) && dec_phase == '0);

    // A run needs two samples before it has a direction; a reversal restarts it.
    always_comb begin
        acq_cnt = GW'(1);
        run_dir = 1'b0;
        if (have_prev_reg && good_cnt_reg >= GW'(2) &&
            (acq_dir_reg ? step_rev : step_fwd)) begin
            acq_cnt = good_cnt_reg + GW'(1);
            run_dir = acq_dir_reg;
        end else if (have_prev_reg && good_cnt_reg == GW'(1) && (step_fwd || step_rev)) begin
            acq_cnt = GW'(2);
            run_dir = !step_fwd;
        end
    end
`else
    assign lock_step_ok = step_fwd;
    assign lock_wrap    = (phase_reg == PW'(WIDTH - 1)) && (dec_phase == '0);
    assign acq_cnt      = step_fwd ? good_cnt_reg + GW'(1) : GW'(1);
`endif

    assign acq_lock = bus.adv && legal && (acq_cnt == GW'(LOCK_CNT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ACQ;
            phase_reg     <= '0;
            valid_reg     <= 1'b0;
            err_reg       <= 1'b0;
            rev_reg       <= '0;
            wrap_reg      <= 1'b0;
            good_cnt_reg  <= '0;
            have_prev_reg <= 1'b0;
`ifdef RING_DEC_BIDIR_EN
            dir_reg       <= 1'b0;
            acq_dir_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            valid_reg     <= valid_next;
            err_reg       <= err_next;
            rev_reg       <= rev_next;
            wrap_reg      <= wrap_next;
            good_cnt_reg  <= good_cnt_next;
            have_prev_reg <= have_prev_next;
`ifdef RING_DEC_BIDIR_EN
            dir_reg       <= dir_next;
            acq_dir_reg   <= acq_dir_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACQ:     if (acq_lock) state_next = LOCK;
            LOCK:    if (bus.adv && !(legal && lock_step_ok)) state_next = ERR;
            ERR:     state_next = ACQ;
            default: state_next = ACQ;
        endcase
    end

    always_comb begin
        phase_next     = phase_reg;
        valid_next     = valid_reg;
        err_next       = 1'b0;
        rev_next       = rev_reg;
        wrap_next      = 1'b0;
        good_cnt_next  = good_cnt_reg;
        have_prev_next = have_prev_reg;
`ifdef RING_DEC_BIDIR_EN
        dir_next       = dir_reg;
        acq_dir_next   = acq_dir_reg;
`endif
        case (state_reg)
            ACQ: begin
                if (bus.adv) begin
                    valid_next = legal;
                    if (legal) begin
                        phase_next     = dec_phase;
                        have_prev_next = 1'b1;
                        good_cnt_next  = acq_cnt;
`ifdef RING_DEC_BIDIR_EN
                        acq_dir_next   = run_dir;
                        if (acq_lock) dir_next = run_dir;
`endif
                    end else begin
                        good_cnt_next  = '0;
                        have_prev_next = 1'b0;
                    end
                end
            end
            LOCK: begin
                if (bus.adv) begin
                    valid_next = legal;
                    if (legal) phase_next = dec_phase;
                    if (!(legal && lock_step_ok)) begin
                        err_next = 1'b1;
                    end else if (lock_wrap) begin
                        rev_next  = rev_reg + REV_W'(1);
                        wrap_next = 1'b1;
                    end
                end
            end
            default: begin
                // ERR: the sample is ignored and acquisition restarts from scratch.
                good_cnt_next  = '0;
                have_prev_next = 1'b0;
            end
        endcase
    end

    assign bus.phase       = phase_reg;
    assign bus.phase_valid = valid_reg;
    assign bus.locked      = (state_reg == LOCK);
    assign bus.err_pulse   = err_reg;
    assign bus.rev_cnt     = rev_reg;
    assign bus.wrap_pulse  = wrap_reg;
`ifdef RING_DEC_BIDIR_EN
    assign bus.dir         = dir_reg;
`endif
endmodule

// File: doc/ring_phase_decoder.md
Name: ring_phase_decoder

Overview:
Receive-side companion to the team's one-hot ring counter.
- Samples a WIDTH-bit one-hot ring code on an advance strobe and decodes it to a binary phase index.
- Verifies that each code is legal and that the ring steps in the expected order. Acquires and loses lock, and counts full revolutions.
- Sits between a ring-counter source and control logic that needs phase, health and revolution count.

Parameters:
WIDTH, 4, number of ring bits (≥2); phase width is PW = $clog2(WIDTH)
LOCK_CNT, 3, consecutive legal, correctly-stepped samples required to declare lock (≥1)
REV_W, 8, width of the revolution counter

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  reset, synchronous, active-high; overrides every other input
ring_in  input  WIDTH  one-hot ring code, synchronous to clk
adv  input  1  sample strobe; ring_in is evaluated only on edges where adv=1
phase  output  PW  decoded phase of last legal sample; MSB set=0, next bit down=1, …, LSB set=WIDTH-1
phase_valid  output  1  last sample was a legal one-hot code
locked  output  1  FSM in LOCK
err_pulse  output  1  one-cycle pulse on loss of lock
rev_cnt  output  REV_W  completed revolutions while locked, modulo 2^REV_W
wrap_pulse  output  1  one-cycle pulse when rev_cnt increments

Behaviour:
- Reset values: phase=0, phase_valid=0, locked=0, err_pulse=0, rev_cnt=0, wrap_pulse=0, state=ACQ, good_cnt=0, have_prev=0.
- Latency: every output reflects the sample taken at the adv edge, registered at that same edge, so it is visible 1 cycle later. With adv=0, state is held and both pulses drop to 0.
- Legal code: exactly one bit set.
  - All-zero or multi-hot codes are illegal. Illegal codes clear phase_valid and leave phase at its previous value.
- Correct step: new_phase == (prev_phase+1) mod WIDTH. Example for WIDTH=4: 1000→0100→0010→0001→1000.
  - A repeated code (same phase twice) is a wrong step.
- State ACQ:
  - Legal sample with have_prev=0 or a wrong step: good_cnt=1.
  - Legal sample with a correct step: good_cnt+1.
  - good_cnt reaching LOCK_CNT: go to LOCK and set locked=1 on that edge. With LOCK_CNT=1, the first legal sample locks.
  - Illegal sample: good_cnt=0, have_prev=0, no err_pulse.
- State LOCK:
  - Correct step: stay in LOCK.
  - Correct step from phase WIDTH-1 to 0: rev_cnt+1 (wrapping to 0 past 2^REV_W-1) and wrap_pulse=1.
  - Illegal or wrong step: go to ERR, err_pulse=1, locked=0.
- State ERR: lasts exactly one clk regardless of adv.
  - Any sample in this cycle is ignored.
  - Then go to ACQ with good_cnt=0 and have_prev=0.
- rev_cnt is held through ERR/ACQ and cleared only by rst.
- rst asserted mid-operation, even coincident with adv: all registers take reset values on that edge.

Optional Feature:
RING_DEC_BIDIR_EN
- Defined:
  - Extra output port dir (1 bit: 0 = forward/descending bit, 1 = reverse).
  - ACQ accepts both +1 and −1 steps. good_cnt counts consecutive steps in one direction; a direction change restarts at 1.
  - The direction is captured into dir at lock.
  - In LOCK, a step opposite to dir is a wrong step.
  - In reverse lock, rev_cnt increments on the 0→WIDTH-1 step.
  - dir resets to 0.
- Undefined: port dir is absent, and a reverse step is always a wrong step.

Test Plan:
- rst=1 for 2 cycles, then idle → all outputs 0, locked=0.
- adv pulses with 1000,0100,0010 → phase 0,1,2; phase_valid=1; locked=1 after the third sample.
- Locked, continue 0001,1000 → phase 3 then 0; rev_cnt 0→1; wrap_pulse high exactly 1 cycle.
- Locked, present 0110 → err_pulse=1 for 1 cycle, locked=0, phase_valid=0, rev_cnt unchanged. Next cycle is in ACQ, and 3 good samples relock.
- Locked at phase 1, present 0010 twice (repeat) → err_pulse on the second sample. Locked, present 0001 after 0100 (skip) → err_pulse.
- Lock, run 256 revolutions with REV_W=8 → rev_cnt wraps to 0. Assert rst together with adv → all outputs reset on that edge.
